// File: rtl/cmd_sender_pkg.sv
// cmd_sender_pkg: shared state encoding and framing constants for the command sender.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmd_sender_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TX_HI = 2'd1,
        GAP   = 2'd2,
        TX_LO = 2'd3
    } snd_state_t;

    // start bit + 8 data bits + stop bit
    localparam int FRAME_BITS   = 10;
    localparam int DEF_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, start bit 0, data LSB-first, stop bit 1.
// Latency: TX drops to the start bit 1 clk after trmt; frame lasts FRAME_BITS*BAUD_DIV clks.
// Backpressure: none; a trmt while sending restarts the frame, so the caller must wait for tx_done.
// Ports: clk, rst_n (async active-low), trmt (load and start), tx_data[7:0],
//        TX (serial line, idles high), tx_done (1-clk pulse as the stop bit ends).
module uart_tx
    import cmd_sender_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV);

    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      baud_cnt;
    logic [3:0]            bit_cnt;
    logic                  sending;
    logic                  baud_last;

    assign baud_last = (baud_cnt == CNT_W'(BAUD_DIV - 1));
    // Combinational so the sequencer can chain the next frame with no dead clock.
    assign tx_done   = sending && baud_last && (bit_cnt == 4'(FRAME_BITS - 1));
    // Gating by sending keeps the line high straight out of reset.
    assign TX        = sending ? shreg[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sending  <= 1'b0;
        end else if (trmt) begin
            shreg    <= {1'b1, tx_data, 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sending  <= 1'b1;
        end else if (sending) begin
            if (baud_last) begin
                baud_cnt <= '0;
                shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
                if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                    bit_cnt <= '0;
                    sending <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cmd_sender.sv
// cmd_sender: serialises a 16-bit command as two UART frames, high byte first.
// Latency: TX falls 1 clk after an accepted snd_cmd; word takes 20*BAUD_DIV clks (21 with the gap).
// Backpressure: snd_cmd is taken only when idle; requests while busy are dropped, not queued.
// Ports: clk, rst_n (async active-low), cmd[15:0], snd_cmd (1-clk request),
//        TX (serial line), busy, cmd_sent (sticky done, cleared by the next accepted request).
// Build option: define CMD_SND_GAP_EN to insert one idle bit period between the two bytes.
module cmd_sender
    import cmd_sender_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);

    snd_state_t  state_q, state_d;
    logic [15:0] cmd_hold;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        accept;
    logic        word_done;

`ifdef CMD_SND_GAP_EN
    localparam int CNT_W = $clog2(BAUD_DIV);
    logic [CNT_W-1:0] gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state_q == GAP) begin
            gap_cnt <= gap_cnt + CNT_W'(1);
        end else begin
            gap_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        trmt      = 1'b0;
        tx_data   = cmd_hold[15:8];
        accept    = 1'b0;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (snd_cmd) begin
                    // cmd_hold is only written on this edge, so feed the live word.
                    accept  = 1'b1;
                    trmt    = 1'b1;
                    tx_data = cmd[15:8];
                    state_d = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_done) begin
`ifdef CMD_SND_GAP_EN
                    state_d = GAP;
`else
                    trmt    = 1'b1;
                    tx_data = cmd_hold[7:0];
                    state_d = TX_LO;
`endif
                end
            end
`ifdef CMD_SND_GAP_EN
            GAP: begin
                if (gap_cnt == CNT_W'(BAUD_DIV - 1)) begin
                    trmt    = 1'b1;
                    tx_data = cmd_hold[7:0];
                    state_d = TX_LO;
                end
            end
`endif
            TX_LO: begin
                if (tx_done) begin
                    word_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_hold <= '0;
            busy     <= 1'b0;
            cmd_sent <= 1'b0;
        end else if (accept) begin
            cmd_hold <= cmd;
            busy     <= 1'b1;
            cmd_sent <= 1'b0;
        end else if (word_done) begin
            busy     <= 1'b0;
            cmd_sent <= 1'b1;
        end
    end

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

endmodule

// File: tb/tb_cmd_sender.sv
// tb_cmd_sender: timing-level reference model of the command sender, per-cycle compare,
// a bench UART receiver as byte scoreboard, and directed plus randomized scenarios.
module tb_cmd_sender;

    localparam int BD = 16;
`ifdef CMD_SND_GAP_EN
    localparam int GAP_CYC = BD;
`else
    localparam int GAP_CYC = 0;
`endif
    localparam int WORD_CYC = 20 * BD + GAP_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        TX, busy, cmd_sent;

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    cmd_sender #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .TX       (TX),
        .busy     (busy),
        .cmd_sent (cmd_sent)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (time arithmetic only) ----------------
    int          cyc = 0;
    bit          m_active = 1'b0;
    bit          m_sent = 1'b0;
    int          m_start = 0;
    logic [15:0] m_word = 16'h0000;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          rx_epoch = 0;

    // Line level k clocks after the accepting edge of word w.
    function automatic logic exp_tx(input int k, input logic [15:0] w);
        logic [7:0] by;
        int b;
        if (k < 10 * BD) begin
            by = w[15:8];
            b  = k / BD;
        end else if (k < 10 * BD + GAP_CYC) begin
            return 1'b1;
        end else begin
            by = w[7:0];
            b  = (k - 10 * BD - GAP_CYC) / BD;
        end
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_sent   = 1'b0;
        end else if (m_active) begin
            if (cyc == m_start + WORD_CYC) begin
                m_active = 1'b0;
                m_sent   = 1'b1;
            end
        end else if (snd_cmd) begin
            m_active = 1'b1;
            m_sent   = 1'b0;
            m_start  = cyc;
            m_word   = cmd;
            exp_q.push_back(cmd[15:8]);
            exp_q.push_back(cmd[7:0]);
        end
    end

    always @(negedge clk) begin
        logic e_tx, e_busy, e_sent;
        if (!rst_n) begin
            e_tx = 1'b1; e_busy = 1'b0; e_sent = 1'b0;
        end else if (m_active) begin
            e_tx = exp_tx(cyc - m_start, m_word); e_busy = 1'b1; e_sent = 1'b0;
        end else begin
            e_tx = 1'b1; e_busy = 1'b0; e_sent = m_sent;
        end
        checks++;
        if (TX !== e_tx || busy !== e_busy || cmd_sent !== e_sent) begin
            errors++;
            if (fail_prints < 20) begin
                fail_prints++;
                $display("FAIL cycle_model cyc=%0d got TX=%b busy=%b cmd_sent=%b, required TX=%b busy=%b cmd_sent=%b",
                         cyc, TX, busy, cmd_sent, e_tx, e_busy, e_sent);
            end
        end
    end

    // ---------------- bench UART receiver ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TX === 1'b0) begin
                int ep;
                logic [7:0] b;
                logic ok;
                ep = rx_epoch;
                ok = 1'b1;
                repeat (8) @(negedge clk);
                if (TX !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BD) @(negedge clk);
                if (TX !== 1'b1) ok = 1'b0;
                if (ep == rx_epoch) begin
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL rx_framing byte=%h got bad start/stop bit, required 0/1", b);
                    end
                    rx_q.push_back(b);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic check_rx(input string name, input logic [15:0] w);
        checks++;
        if (rx_q.size() != 2 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL %s_count: got rx=%0d model=%0d bytes, required 2", name, rx_q.size(), exp_q.size());
        end else begin
            chk({name, "_rx_bytes"}, {16'h0, rx_q[0], rx_q[1]}, {16'h0, w});
            chk({name, "_model_bytes"}, {16'h0, exp_q[0], exp_q[1]}, {16'h0, w});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [15:0] w);
        @(posedge clk); #1;
        cmd = w; snd_cmd = 1'b1;
        @(posedge clk); #1;
        snd_cmd = 1'b0; cmd = 16'($urandom);
    endtask

    task automatic pulse(input logic [15:0] w);
        cmd = w; snd_cmd = 1'b1;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(cmd_sent === 1'b1 && busy === 1'b0) && n < WORD_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(cmd_sent === 1'b1 && busy === 1'b0)) begin
            errors++;
            $display("FAIL %s_timeout: got cmd_sent=%b busy=%b after %0d clks, required 1/0", name, cmd_sent, busy, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic scen_basic();
        logic [19:0] seq_v = 20'b0101001011_0110000111;
        int k = 0;
        send(16'hA5C3);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            int tgt = (i < 10) ? 8 + BD * i : 8 + BD * i + GAP_CYC;
            while (k < tgt) begin @(negedge clk); k++; end
            chk($sformatf("a5c3_bit%0d", i), {31'h0, TX}, {31'h0, seq_v[19-i]});
        end
        while (cmd_sent !== 1'b1 && k < WORD_CYC + 50) begin @(negedge clk); k++; end
        chk("cmd_sent_time", k, 20 * BD + GAP_CYC);
        chk("busy_after_word", {31'h0, busy}, 32'h0);
        check_rx("a5c3", 16'hA5C3);
    endtask

    task automatic scen_ignore();
        send(16'hA5C3);
        repeat (48) @(posedge clk); #1;
        pulse(16'h1234);
        wait_done("ignore");
        repeat (200) @(negedge clk);
        chk("ignore_busy", {31'h0, busy}, 32'h0);
        chk("ignore_sent", {31'h0, cmd_sent}, 32'h1);
        check_rx("ignore", 16'hA5C3);
    endtask

    task automatic scen_reset();
        send(16'h5A5A);
        repeat (70) @(posedge clk);
        #3 rst_n = 1'b0;
        rx_epoch++;
        #1;
        chk("arst_TX", {31'h0, TX}, 32'h1);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_sent", {31'h0, cmd_sent}, 32'h0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (160) @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        send(16'h0000);
        wait_done("after_reset");
        check_rx("after_reset", 16'h0000);
    endtask

    task automatic scen_b2b();
        logic [15:0] w1 = 16'($urandom);
        int n = 0;
        send(w1);
        while (cmd_sent !== 1'b1 && n < WORD_CYC + 50) begin @(negedge clk); n++; end
        check_rx("b2b_first", w1);
        pulse(16'hFFFF);
        chk("b2b_sent_clear", {31'h0, cmd_sent}, 32'h0);
        chk("b2b_busy", {31'h0, busy}, 32'h1);
        chk("b2b_TX_fall", {31'h0, TX}, 32'h0);
        wait_done("b2b");
        check_rx("b2b_second", 16'hFFFF);
    endtask

    task automatic scen_random();
        for (int r = 0; r < 6; r++) begin
            logic [15:0] w = 16'($urandom);
            send(w);
            if (r % 2 == 0) begin
                // request while busy at a random point
                repeat ($urandom_range(1, 300)) @(posedge clk); #1;
                pulse(16'($urandom));
            end else begin
                // request on the very edge that completes the word
                repeat (WORD_CYC - 1) @(posedge clk); #1;
                pulse(16'($urandom));
            end
            wait_done("rand");
            repeat ($urandom_range(2, 40)) @(negedge clk);
            chk("rand_no_restart", {31'h0, busy}, 32'h0);
            check_rx($sformatf("rand%0d", r), w);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("reset_TX", {31'h0, TX}, 32'h1);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_sent", {31'h0, cmd_sent}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        scen_basic();
        scen_ignore();
        scen_reset();
        scen_b2b();
        scen_random();
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
